// File: rtl/systolic_column_drain_if.sv
// Bus between the systolic column drain and its neighbours.
//   - Upstream side: skewed column sums from the bottom row of the array.
//   - Downstream side: deskewed, saturated row vectors over valid/ready.
//   - Status side: sticky saturation and overflow flags, and a busy indication.
// The slave modport is the drain; the master modport is whoever surrounds it.
interface systolic_column_drain_if #(
  parameter int NUM_COLS          = 4,
  parameter int ACC_WIDTH         = 20,
  parameter int FIXED_POINT_WIDTH = 16
);
  logic                                  sums_valid_in;
  logic [NUM_COLS*ACC_WIDTH-1:0]         column_sums_in;
  logic                                  result_valid_out;
  logic                                  result_ready_in;
  logic [NUM_COLS*FIXED_POINT_WIDTH-1:0] result_data_out;
  logic                                  saturated_out;
  logic                                  overflow_out;
  logic                                  busy_out;

  modport slave (
    input  sums_valid_in,
    input  column_sums_in,
    input  result_ready_in,
    output result_valid_out,
    output result_data_out,
    output saturated_out,
    output overflow_out,
    output busy_out
  );

  modport master (
    output sums_valid_in,
    output column_sums_in,
    output result_ready_in,
    input  result_valid_out,
    input  result_data_out,
    input  saturated_out,
    input  overflow_out,
    input  busy_out
  );
endinterface

// File: rtl/systolic_column_drain.sv
// Systolic column drain.
// Collects the bottom-row partial sums of a systolic array, removes the
// one-cycle-per-column skew, saturates each column to the fixed-point
// activation width and queues whole row vectors in a show-ahead FIFO.
//
// Optional feature macro: SYSTOLIC_DRAIN_RELU_EN
//   defined   -> negative column sums are forced to 0 before saturation, so
//                only positive clipping can raise the saturation flag.
//   undefined -> pure signed saturation.
//
// Timing for a row whose column 0 arrives with sums_valid_in at cycle t:
//   t .. t+NUM_COLS-1 : column j arrives at t+j and is delayed NUM_COLS-1-j
//                       cycles, so every column is aligned in cycle t+NUM_COLS-1
//   t+NUM_COLS        : saturated row sits in the saturation register and is
//                       written into the FIFO at the end of this cycle
//   t+NUM_COLS+1      : result_valid_out is high (empty FIFO, no bypass)
//
// Handshake: result_valid_out means the FIFO head holds a row vector and
// result_data_out shows it; the head is consumed on any rising clock edge where
// result_valid_out && result_ready_in. While valid is high and ready is low the
// head, and therefore result_data_out, does not change. There is no input-side
// backpressure: a row that reaches a full FIFO with no same-cycle pop is dropped
// and overflow_out latches high.
//
// FIXED_POINT_POSITION is informational only: input and output share the same
// fractional scale, so no shift is applied.
module systolic_column_drain #(
  parameter int NUM_COLS             = 4,
  parameter int ACC_WIDTH            = 20,
  parameter int FIXED_POINT_WIDTH    = 16,
  parameter int FIXED_POINT_POSITION = 10,
  parameter int FIFO_DEPTH           = 8
) (
  input logic                    clk_in,
  input logic                    rst_in,
  systolic_column_drain_if.slave bus
);

  localparam int FW = FIXED_POINT_WIDTH;
  localparam int RW = NUM_COLS * FW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // Saturation bounds expressed at the accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-FW+1){1'b1}}, {(FW-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Deskew
  // ---------------------------------------------------------------------------
  logic [NUM_COLS-1:0]          valid_sr;
  logic                         aligned_valid;
  logic signed [ACC_WIDTH-1:0]  aligned [NUM_COLS];

  // Track row starts; bit k is high k+1 cycles after sums_valid_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[NUM_COLS-2:0], bus.sums_valid_in};
    end
  end

  // Row is fully aligned NUM_COLS-1 cycles after its column 0 arrived.
  assign aligned_valid = valid_sr[NUM_COLS-2];

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    localparam int DEPTH = NUM_COLS - 1 - j;
    logic [ACC_WIDTH-1:0] col_now;
    assign col_now = bus.column_sums_in[j*ACC_WIDTH +: ACC_WIDTH];

    if (DEPTH == 0) begin : g_direct
      // The last column arrives already aligned.
      assign aligned[j] = col_now;
    end else begin : g_pipe
      logic [ACC_WIDTH-1:0] stage [DEPTH];

      // Delay column j by DEPTH cycles so it lines up with the last column.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int k = 0; k < DEPTH; k++) begin
            stage[k] <= '0;
          end
        end else begin
          stage[0] <= col_now;
          for (int k = 1; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end

      assign aligned[j] = stage[DEPTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] col_val [NUM_COLS];
  logic [RW-1:0]               sat_row_next;
  logic                        clip_any;
  logic                        sat_valid;
  logic [RW-1:0]               sat_row;
  logic                        saturated;

  // Clamp each aligned column to the signed output range and flag any clipping.
  always_comb begin
    sat_row_next = '0;
    clip_any     = 1'b0;
    for (int j = 0; j < NUM_COLS; j++) begin
      col_val[j] = aligned[j];
`ifdef SYSTOLIC_DRAIN_RELU_EN
      if (col_val[j] < 0) begin
        col_val[j] = '0;
      end
`endif
      if (col_val[j] > SAT_MAX) begin
        sat_row_next[j*FW +: FW] = {1'b0, {(FW-1){1'b1}}};
        clip_any                 = 1'b1;
      end else if (col_val[j] < SAT_MIN) begin
        sat_row_next[j*FW +: FW] = {1'b1, {(FW-1){1'b0}}};
        clip_any                 = 1'b1;
      end else begin
        sat_row_next[j*FW +: FW] = col_val[j][FW-1:0];
      end
    end
  end

  // Register the saturated row; clipping is only counted for real rows.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sat_valid <= 1'b0;
      sat_row   <= '0;
      saturated <= 1'b0;
    end else begin
      sat_valid <= aligned_valid;
      if (aligned_valid) begin
        sat_row <= sat_row_next;
      end
      if (aligned_valid && clip_any) begin
        saturated <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          overflow;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop  = !fifo_empty && bus.result_ready_in;
  // A full FIFO still takes a row when the head leaves in the same cycle.
  assign push = sat_valid && (!fifo_full || pop);
  assign drop = sat_valid && fifo_full && !pop;

  // Storage; cleared on reset so the idle output reads as zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= sat_row;
    end
  end

  // Pointer and sticky overflow bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.result_valid_out = !fifo_empty;
  assign bus.result_data_out  = mem[rd_ptr[AW-1:0]];
  assign bus.saturated_out    = saturated;
  assign bus.overflow_out     = overflow;
  assign bus.busy_out         = (|valid_sr) | sat_valid;

endmodule

// File: tb/tb_systolic_column_drain.sv
// Self-checking bench for systolic_column_drain (NUM_COLS=4, ACC_WIDTH=20,
// FIXED_POINT_WIDTH=16, FIFO_DEPTH=8). Expected values honour
// SYSTOLIC_DRAIN_RELU_EN when the bench is built with it.
module tb_systolic_column_drain;

  localparam int NC  = 4;
  localparam int ACW = 20;
  localparam int FW  = 16;

  typedef struct {
    int          s [NC];
    logic [63:0] e;
    logic        sat;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_column_drain_if #(.NUM_COLS(NC), .ACC_WIDTH(ACW), .FIXED_POINT_WIDTH(FW)) bus ();

  systolic_column_drain #(
    .NUM_COLS(NC), .ACC_WIDTH(ACW), .FIXED_POINT_WIDTH(FW),
    .FIXED_POINT_POSITION(10), .FIFO_DEPTH(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic        ready = 1'b0;
  logic        hv [NC];
  logic [79:0] hrow [NC];
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference saturation for one column sum.
  function automatic logic [15:0] sat_model(input int v_in);
    int v;
    v = v_in;
`ifdef SYSTOLIC_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [79:0] pack_row(input int c0, input int c1, input int c2, input int c3);
    logic [79:0] r;
    r = {c3[19:0], c2[19:0], c1[19:0], c0[19:0]};
    return r;
  endfunction

  function automatic logic [63:0] model_row(input logic [79:0] r);
    logic [63:0] o;
    logic [19:0] f;
    int v;
    o = '0;
    for (int j = 0; j < NC; j++) begin
      f = r[j*ACW +: ACW];
      v = int'($signed(f));
      o[j*FW +: FW] = sat_model(v);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of skewed input; column j carries the row issued
  // j cycles earlier.
  // ---------------------------------------------------------------------------
  task automatic tick(input logic v, input logic [79:0] r);
    for (int k = NC - 1; k > 0; k--) begin
      hv[k]   = hv[k-1];
      hrow[k] = hrow[k-1];
    end
    hv[0]   = v;
    hrow[0] = r;
    bus.sums_valid_in = v;
    for (int j = 0; j < NC; j++) begin
      bus.column_sums_in[j*ACW +: ACW] = hv[j] ? hrow[j][j*ACW +: ACW] : 20'h0;
    end
    bus.result_ready_in = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [79:0] r, input logic [63:0] e);
    exp_q.push_back(e);
    tick(1'b1, r);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NC; k++) begin
      hv[k]   = 1'b0;
      hrow[k] = '0;
    end
    bus.sums_valid_in   = 1'b0;
    bus.column_sums_in  = '0;
    ready               = 1'b0;
    bus.result_ready_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: checks every popped head against the expected queue and checks
  // that a stalled head holds still.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.result_valid_out)
        check("stall_hold", bus.result_data_out, data_prev);
      if (bus.result_valid_out && bus.result_ready_in) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got %h expected no row", bus.result_data_out);
        end else begin
          check("pop_data", bus.result_data_out, exp_q.pop_front());
        end
      end
      stall_prev = bus.result_valid_out && !bus.result_ready_in;
      data_prev  = bus.result_data_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t        tbl [5];
  logic [79:0] r;
  logic        sat_before;
  int          issued;
  int          cycles;
  int          v;

  initial begin
    // Hand-computed table: column 0 first in s, column 0 lowest in e.
    tbl[0].s = '{1000, 2000, -3000, 4};
    tbl[1].s = '{0, -1, 32767, -32768};
    tbl[2].s = '{-500, 1, 2, 3};
    tbl[3].s = '{40000, -40000, 32767, -32768};
    tbl[4].s = '{524287, -524288, 32768, -32769};
`ifdef SYSTOLIC_DRAIN_RELU_EN
    tbl[0].e = {16'h0004, 16'h0000, 16'h07D0, 16'h03E8}; tbl[0].sat = 1'b0;
    tbl[1].e = {16'h0000, 16'h7FFF, 16'h0000, 16'h0000}; tbl[1].sat = 1'b0;
    tbl[2].e = {16'h0003, 16'h0002, 16'h0001, 16'h0000}; tbl[2].sat = 1'b0;
    tbl[3].e = {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF}; tbl[3].sat = 1'b1;
    tbl[4].e = {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF}; tbl[4].sat = 1'b1;
`else
    tbl[0].e = {16'h0004, 16'hF448, 16'h07D0, 16'h03E8}; tbl[0].sat = 1'b0;
    tbl[1].e = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000}; tbl[1].sat = 1'b0;
    tbl[2].e = {16'h0003, 16'h0002, 16'h0001, 16'hFE0C}; tbl[2].sat = 1'b0;
    tbl[3].e = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}; tbl[3].sat = 1'b1;
    tbl[4].e = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}; tbl[4].sat = 1'b1;
`endif

    // Reset state.
    do_reset();
    check("rst_valid", 64'(bus.result_valid_out), 64'd0);
    check("rst_data",  bus.result_data_out,       64'd0);
    check("rst_sat",   64'(bus.saturated_out),    64'd0);
    check("rst_ovf",   64'(bus.overflow_out),     64'd0);
    check("rst_busy",  64'(bus.busy_out),         64'd0);

    // Table: single rows with ready=1; latency, pulse width, sticky saturation.
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sat_before = (i == 0) ? 1'b0 : tbl[i-1].sat;
      r = pack_row(tbl[i].s[0], tbl[i].s[1], tbl[i].s[2], tbl[i].s[3]);
      issue(r, tbl[i].e);
      for (int k = 1; k <= 7; k++) begin
        check($sformatf("tbl%0d_valid_t%0d", i, k), 64'(bus.result_valid_out), 64'(k == 5));
        if (k == 1) check($sformatf("tbl%0d_busy", i), 64'(bus.busy_out), 64'd1);
        if (k == 3) check($sformatf("tbl%0d_sat_pre", i), 64'(bus.saturated_out), 64'(sat_before));
        if (k == 4) check($sformatf("tbl%0d_sat_post", i), 64'(bus.saturated_out), 64'(tbl[i].sat));
        tick(1'b0, '0);
      end
      check($sformatf("tbl%0d_idle", i), 64'(bus.busy_out), 64'd0);
      check($sformatf("tbl%0d_drained", i), 64'(exp_q.size()), 64'd0);
    end

    // Ten back-to-back rows into a stalled FIFO: first eight kept.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      r = pack_row(i*100 + 1, i*100 + 2, -(i*100 + 3), i);
      if (i < 8) issue(r, model_row(r));
      else tick(1'b1, r);
    end
    repeat (6) tick(1'b0, '0);
    check("ovf_set",        64'(bus.overflow_out),     64'd1);
    check("ovf_full_valid", 64'(bus.result_valid_out), 64'd1);
    ready = 1'b1;
    repeat (10) tick(1'b0, '0);
    check("ovf_drained", 64'(exp_q.size()),        64'd0);
    check("ovf_empty",   64'(bus.result_valid_out), 64'd0);

    // Full FIFO receives a row in the same cycle the head is popped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r = pack_row(i + 7, -i, i*3, 1000 - i);
      issue(r, model_row(r));
    end
    repeat (6) tick(1'b0, '0);
    check("full_valid", 64'(bus.result_valid_out), 64'd1);
    r = pack_row(11111, -22222, 333, -44);
    issue(r, model_row(r));
    repeat (3) tick(1'b0, '0);
    ready = 1'b1;
    tick(1'b0, '0);
    ready = 1'b0;
    repeat (2) tick(1'b0, '0);
    check("pushpop_no_ovf", 64'(bus.overflow_out), 64'd0);
    check("pushpop_pending", 64'(exp_q.size()), 64'd8);
    ready = 1'b1;
    repeat (12) tick(1'b0, '0);
    check("pushpop_drained", 64'(exp_q.size()),        64'd0);
    check("pushpop_empty",   64'(bus.result_valid_out), 64'd0);
    check("pushpop_ovf_end", 64'(bus.overflow_out),     64'd0);

    // Reset in the middle of a saturating row: nothing may come out.
    do_reset();
    ready = 1'b1;
    tick(1'b1, pack_row(40000, -40000, 1, 2));
    tick(1'b0, '0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.result_valid_out), 64'd0);
    check("midrst_data",  bus.result_data_out,       64'd0);
    check("midrst_busy",  64'(bus.busy_out),         64'd0);
    check("midrst_sat",   64'(bus.saturated_out),    64'd0);
    check("midrst_ovf",   64'(bus.overflow_out),     64'd0);
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, '0);
      check($sformatf("midrst_quiet_t%0d", k), 64'(bus.result_valid_out), 64'd0);
    end
    check("midrst_sat_after", 64'(bus.saturated_out), 64'd0);

    // Random backpressure over 1000 rows; at most eight rows outstanding.
    do_reset();
    issued = 0;
    cycles = 0;
    while ((issued < 1000 || exp_q.size() > 0) && cycles < 20000) begin
      ready = 1'($urandom_range(0, 1));
      if (issued < 1000 && exp_q.size() < 8 && $urandom_range(0, 3) != 0) begin
        r = '0;
        for (int j = 0; j < NC; j++) begin
          v = int'($urandom_range(0, 100000)) - 50000;
          r[j*ACW +: ACW] = v[19:0];
        end
        issue(r, model_row(r));
        issued++;
      end else begin
        tick(1'b0, '0);
      end
      cycles++;
    end
    if (cycles >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL bp_timeout: got %0d rows pending expected 0", exp_q.size());
    end
    check("bp_issued", 64'(issued),           64'd1000);
    check("bp_no_ovf", 64'(bus.overflow_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
